// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter.
// Shares the single RF write port between the MEM/WB writeback and a
// long-latency unit whose results wait in a small circular queue and drain
// into idle writeback slots. A starvation counter forces one drain (with a
// one-cycle pipeline stall) after STARVE_MAX consecutive denied cycles.
// Optional feature macro: WB_ARB_CHK_EN builds the pending-write compare
// logic behind chk_hit_o; without it chk_hit_o is tied low.
module wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_addr_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_addr_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              stall_o,
    output logic              busy_o,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              chk_hit_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);

    // Who owns the write port this cycle
    typedef enum logic [1:0] {
        GR_NONE,
        GR_PIPE,
        GR_HEAD,
        GR_FORCE
    } grant_e;

    // Queue storage
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [ADDR_W-1:0]     addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;

    grant_e grant;
    logic   empty;
    logic   full;
    logic   force_drain;
    logic   head_grant;
    logic   enq;
    logic   deq;
    logic   kill;

    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign head_live = live_q[rptr_q];
    assign head_addr = addr_q[rptr_q];
    assign head_data = data_q[rptr_q];

    // Grant decision and handshake qualifiers
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CNT_FULL);
        force_drain = !empty && (starve_q == STARVE_TOP);
        grant       = GR_NONE;
        if (force_drain) begin
            grant = GR_FORCE;
        end else if (pipe_we_i) begin
            grant = GR_PIPE;
        end else if (!empty) begin
            grant = GR_HEAD;
        end
        head_grant = (grant == GR_HEAD) || (grant == GR_FORCE);
        // r0 results are accepted but dropped; no acceptance when full
        enq        = lu_valid_i && !full && (lu_addr_i != '0);
        deq        = head_grant;
        kill       = (grant == GR_PIPE) && (pipe_addr_i != '0);
    end

    // Port outputs; forced to zero while reset is asserted
    always_comb begin
        rf_we_o    = 1'b0;
        rf_addr_o  = '0;
        rf_data_o  = '0;
        stall_o    = 1'b0;
        lu_ready_o = !full;
        busy_o     = !empty;
        unique case (grant)
            GR_PIPE: begin
                rf_we_o   = 1'b1;
                rf_addr_o = pipe_addr_i;
                rf_data_o = pipe_data_i;
            end
            GR_HEAD: begin
                rf_we_o   = head_live;
                rf_addr_o = head_addr;
                rf_data_o = head_data;
            end
            GR_FORCE: begin
                rf_we_o   = head_live;
                rf_addr_o = head_addr;
                rf_data_o = head_data;
                stall_o   = 1'b1;
            end
            default: begin
                rf_we_o = 1'b0;
            end
        endcase
        if (!rst_i) begin
            rf_we_o    = 1'b0;
            rf_addr_o  = '0;
            rf_data_o  = '0;
            stall_o    = 1'b0;
            lu_ready_o = 1'b0;
            busy_o     = 1'b0;
        end
    end

    // Next-state for pointers, occupancy, starvation counter and live bits
    always_comb begin
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        live_d   = live_q;

        if (deq) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (enq) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (head_grant || empty) begin
            starve_d = '0;
        end else if ((grant == GR_PIPE) && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + SC_W'(1);
        end

        // Kill is applied before the enqueue write so a same-cycle entry survives
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (kill && (addr_q[i] == pipe_addr_i)) begin
                live_d[i] = 1'b0;
            end
            if (deq && (rptr_q == PTR_W'(i))) begin
                live_d[i] = 1'b0;
            end
            if (enq && (wptr_q == PTR_W'(i))) begin
                live_d[i] = 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            live_q   <= '0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            live_q   <= live_d;
        end
    end

    // Queue payload storage, written only on enqueue
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[wptr_q] <= lu_addr_i;
            data_q[wptr_q] <= lu_data_i;
        end
    end

`ifdef WB_ARB_CHK_EN
    logic             chk_any;
    logic [PTR_W-1:0] chk_off;

    // Pending-write lookup over occupied, still-live queue entries
    always_comb begin
        chk_any = 1'b0;
        chk_off = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            chk_off = PTR_W'(i) - rptr_q;
            if (({1'b0, chk_off} < count_q) && live_q[i] &&
                (addr_q[i] == chk_addr_i)) begin
                chk_any = 1'b1;
            end
        end
        chk_hit_o = rst_i && chk_any && (chk_addr_i != '0);
    end
`else
    logic unused_chk_addr;

    assign unused_chk_addr = ^chk_addr_i;
    assign chk_hit_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table, hand-written corner sequences and random
// traffic for wb_arbiter, checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

`ifdef WB_ARB_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          pipe_we_i;
    logic [AW-1:0] pipe_addr_i;
    logic [DW-1:0] pipe_data_i;
    logic          lu_valid_i;
    logic [AW-1:0] lu_addr_i;
    logic [DW-1:0] lu_data_i;
    logic          lu_ready_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_addr_o;
    logic [DW-1:0] rf_data_o;
    logic          stall_o;
    logic          busy_o;
    logic [AW-1:0] chk_addr_i;
    logic          chk_hit_o;

    wb_arbiter #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .FIFO_DEPTH(DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pipe_we_i  (pipe_we_i),
        .pipe_addr_i(pipe_addr_i),
        .pipe_data_i(pipe_data_i),
        .lu_valid_i (lu_valid_i),
        .lu_addr_i  (lu_addr_i),
        .lu_data_i  (lu_data_i),
        .lu_ready_o (lu_ready_o),
        .rf_we_o    (rf_we_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_o  (rf_data_o),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .chk_addr_i (chk_addr_i),
        .chk_hit_o  (chk_hit_o)
    );

    always #5 clk = ~clk;

    // Reference model: pending results as an ordered queue
    typedef struct {
        bit          live;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   starve = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    typedef struct {
        bit          pwe;
        bit [AW-1:0] pa;
        bit [DW-1:0] pd;
        bit          lv;
        bit [AW-1:0] la;
        bit [DW-1:0] ld;
        bit          we;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
        bit          st;
        bit          busy;
        bit          rdy;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit pwe, input bit [AW-1:0] pa, input bit [DW-1:0] pd,
                          input bit lv, input bit [AW-1:0] la, input bit [DW-1:0] ld,
                          input bit [AW-1:0] ca);
        pipe_we_i   = pwe;
        pipe_addr_i = pa;
        pipe_data_i = pd;
        lu_valid_i  = lv;
        lu_addr_i   = la;
        lu_data_i   = ld;
        chk_addr_i  = ca;
    endtask

    // Decide the cycle's winner from the queue contents and the current inputs
    task automatic model_grant(output bit frc, output bit hg, output bit pg);
        frc = (starve >= SMAX) && (q.size() > 0);
        pg  = !frc && pipe_we_i;
        hg  = (q.size() > 0) && (frc || !pipe_we_i);
    endtask

    task automatic check_model();
        bit frc, hg, pg, hit;
        model_grant(frc, hg, pg);
        hit = 1'b0;
        foreach (q[i]) if (q[i].live && q[i].addr == chk_addr_i) hit = 1'b1;
        hit = CHK && hit && (chk_addr_i != 0);
        check("m_stall", stall_o, frc);
        check("m_busy", busy_o, q.size() > 0);
        check("m_ready", lu_ready_o, q.size() < DEPTH);
        check("m_hit", chk_hit_o, hit);
        if (pg) begin
            check("m_we", rf_we_o, 1);
            check("m_addr", rf_addr_o, pipe_addr_i);
            check("m_data", rf_data_o, pipe_data_i);
        end else if (hg) begin
            check("m_we", rf_we_o, q[0].live);
            check("m_addr", rf_addr_o, q[0].addr);
            check("m_data", rf_data_o, q[0].data);
        end else begin
            check("m_we", rf_we_o, 0);
        end
    endtask

    // Clock edge, then apply the same rules to the model state
    task automatic advance();
        bit frc, hg, pg, was_empty, rdy;
        ent_t e;
        @(posedge clk);
        model_grant(frc, hg, pg);
        was_empty = (q.size() == 0);
        rdy       = (q.size() < DEPTH);
        if (hg) void'(q.pop_front());
        if (pg && pipe_addr_i != 0) begin
            foreach (q[i]) if (q[i].addr == pipe_addr_i) q[i].live = 1'b0;
        end
        if (hg || was_empty) starve = 0;
        else if (pg && starve < SMAX) starve++;
        if (lu_valid_i && rdy && lu_addr_i != 0) begin
            e.live = 1'b1;
            e.addr = lu_addr_i;
            e.data = lu_data_i;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st;
        bit          prev_st;
        int          stall_at;
        int          n_st;
        bit [DW-1:0] pd;

        tbl[0]  = '{0, 0, 0,       0, 0,  0,      0, 0,  0,       0, 0, 1};
        tbl[1]  = '{0, 0, 0,       1, 3,  'h11,   0, 0,  0,       0, 0, 1};
        tbl[2]  = '{0, 0, 0,       0, 0,  0,      1, 3,  'h11,    0, 1, 1};
        tbl[3]  = '{0, 0, 0,       0, 0,  0,      0, 0,  0,       0, 0, 1};
        tbl[4]  = '{0, 0, 0,       1, 0,  'h55,   0, 0,  0,       0, 0, 1};
        tbl[5]  = '{0, 0, 0,       0, 0,  0,      0, 0,  0,       0, 0, 1};
        tbl[6]  = '{1, 1, 'h101,   1, 10, 'hA0,   1, 1,  'h101,   0, 0, 1};
        tbl[7]  = '{1, 1, 'h102,   1, 11, 'hA1,   1, 1,  'h102,   0, 1, 1};
        tbl[8]  = '{1, 1, 'h103,   1, 12, 'hA2,   1, 1,  'h103,   0, 1, 1};
        tbl[9]  = '{1, 1, 'h104,   1, 13, 'hA3,   1, 1,  'h104,   0, 1, 1};
        tbl[10] = '{1, 1, 'h105,   1, 14, 'hA4,   1, 1,  'h105,   0, 1, 0};
        tbl[11] = '{1, 1, 'h106,   1, 14, 'hA4,   1, 1,  'h106,   0, 1, 0};
        tbl[12] = '{0, 0, 0,       1, 14, 'hA4,   1, 10, 'hA0,    0, 1, 0};
        tbl[13] = '{0, 0, 0,       1, 14, 'hA4,   1, 11, 'hA1,    0, 1, 1};
        tbl[14] = '{0, 0, 0,       0, 0,  0,      1, 12, 'hA2,    0, 1, 1};
        tbl[15] = '{0, 0, 0,       0, 0,  0,      1, 13, 'hA3,    0, 1, 1};
        tbl[16] = '{0, 0, 0,       0, 0,  0,      1, 14, 'hA4,    0, 1, 1};
        tbl[17] = '{0, 0, 0,       0, 0,  0,      0, 0,  0,       0, 0, 1};

        // Reset with live-looking inputs: every output held at zero
        rst_i = 1'b0;
        set_in(1, 9, 'hDEAD, 1, 4, 'hBEEF, 9);
        #2;
        check("rst_we", rf_we_o, 0);
        check("rst_addr", rf_addr_o, 0);
        check("rst_data", rf_data_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_ready", lu_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_hit", chk_hit_o, 0);
        #10;
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Directed table: idle drain, r0 drop, fill/backpressure, ordered drain
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld, 0);
            @(negedge clk);
            check($sformatf("t%0d_we", i), rf_we_o, tbl[i].we);
            if (tbl[i].we) begin
                check($sformatf("t%0d_addr", i), rf_addr_o, tbl[i].a);
                check($sformatf("t%0d_data", i), rf_data_o, tbl[i].d);
            end
            check($sformatf("t%0d_stall", i), stall_o, tbl[i].st);
            check($sformatf("t%0d_busy", i), busy_o, tbl[i].busy);
            check($sformatf("t%0d_ready", i), lu_ready_o, tbl[i].rdy);
            check_model();
            advance();
        end

        // Starvation: r5 queued, pipe writing every cycle
        set_in(1, 1, 'h200, 1, 5, 'h55, 0);
        cyc();
        pd       = 'h300;
        stall_at = 0;
        n_st     = 0;
        prev_st  = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            set_in(1, 2, pd, 0, 0, 0, 0);
            @(negedge clk);
            st = stall_o;
            if (st) begin
                n_st++;
                if (stall_at == 0) stall_at = k;
                check("force_addr", rf_addr_o, 5);
                check("force_data", rf_data_o, 'h55);
            end
            if (prev_st) begin
                check("represent_we", rf_we_o, 1);
                check("represent_addr", rf_addr_o, 2);
                check("represent_data", rf_data_o, pd);
            end
            check_model();
            advance();
            prev_st = st;
            if (!st) pd = pd + 1;
        end
        check("stall_cycle", stall_at, 9);
        check("stall_count", n_st, 1);

        // WAW kill and pending-write lookup
        set_in(1, 2, 'h1, 1, 7, 'hAA, 7);
        @(negedge clk);
        check("hit_enq_cycle", chk_hit_o, 0);
        check_model();
        advance();
        set_in(1, 2, 'h2, 0, 0, 0, 7);
        @(negedge clk);
        check("hit_pending", chk_hit_o, CHK);
        check_model();
        advance();
        set_in(1, 7, 'hBB, 0, 0, 0, 7);
        @(negedge clk);
        check("hit_before_kill", chk_hit_o, CHK);
        check("kill_pipe_data", rf_data_o, 'hBB);
        check_model();
        advance();
        set_in(0, 0, 0, 0, 0, 0, 7);
        @(negedge clk);
        check("hit_after_kill", chk_hit_o, 0);
        check("killed_drain_we", rf_we_o, 0);
        check("killed_drain_busy", busy_o, 1);
        check_model();
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Reset mid-operation with three queued entries
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 'h400 + k, 1, 20 + k, 'h500 + k, 0);
            cyc();
        end
        set_in(1, 3, 'h77, 1, 22, 'h9, 21);
        #2;
        rst_i = 1'b0;
        #1;
        check("mrst_we", rf_we_o, 0);
        check("mrst_addr", rf_addr_o, 0);
        check("mrst_data", rf_data_o, 0);
        check("mrst_stall", stall_o, 0);
        check("mrst_ready", lu_ready_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_hit", chk_hit_o, 0);
        q.delete();
        starve = 0;
        @(posedge clk);
        #1;
        check("mrst_busy_held", busy_o, 0);
        #3;
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 21);
        @(negedge clk);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_we", rf_we_o, 0);
        check_model();
        advance();

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom % 10) < 7, AW'($urandom % 8), $urandom,
                   $urandom % 2, AW'($urandom % 8), $urandom, AW'($urandom % 8));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter at the end of the pipeline. It shares the single register-file write port between the MEM/WB pipeline writeback and a long-latency unit (divider or multi-cycle multiplier). Long-latency results queue in a small FIFO and drain into idle writeback slots. A starvation counter freezes the pipeline for one cycle when the queue has waited too long.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, long-latency result queue entries (power of two, ≥2)
- STARVE_MAX, 8, consecutive denied cycles before a forced drain (≥1)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- pipe_we_i  in  1  MEM/WB RegWrite
- pipe_addr_i  in  ADDR_W  MEM/WB destination register
- pipe_data_i  in  DATA_W  MEM/WB writeback mux result
- lu_valid_i  in  1  long-latency result valid
- lu_addr_i  in  ADDR_W  long-latency destination register
- lu_data_i  in  DATA_W  long-latency result
- lu_ready_o  out  1  queue can accept; transfer on lu_valid_i & lu_ready_o
- rf_we_o  out  1  register-file write enable
- rf_addr_o  out  ADDR_W  register-file write address
- rf_data_o  out  DATA_W  register-file write data
- stall_o  out  1  freeze MEM/WB and all earlier stages this cycle
- busy_o  out  1  queue non-empty
- chk_addr_i  in  ADDR_W  decode-stage source register to check
- chk_hit_o  out  1  chk_addr_i has a live pending write in the queue

## Operation
- Queue: circular FIFO. Each entry holds {live, addr, data}. Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. A count register ranges 0..FIFO_DEPTH.
- lu_ready_o = (count != FIFO_DEPTH). No pass-through when full: ready stays 0 even if a dequeue happens the same cycle.
- Accepted results with addr 0 are consumed (ready honoured) but never enqueued.
- Grant per cycle, combinational:
  - Force: starve count == STARVE_MAX and queue non-empty. stall_o=1. Head entry drives the port. Pipe write is not consumed; the pipeline re-presents it next cycle.
  - Otherwise, if pipe_we_i=1, the pipe drives the port.
  - Otherwise, if the queue is non-empty, the head drives the port.
- Dequeue on every head grant. rf_we_o = head.live, so killed entries drain with write suppressed.
- Starve counter:
  - Increments when the queue is non-empty and the pipe takes the port.
  - Clears on any head grant or when the queue is empty.
  - Saturates at STARVE_MAX.
- WAW kill: a consumed pipe write (pipe_we_i, no force, addr≠0) clears live on every queued entry with a matching addr. An entry enqueued in the same cycle is not killed.
- chk_hit_o = OR over occupied live entries with addr == chk_addr_i and chk_addr_i≠0. Entries being enqueued this cycle are excluded.

## Timing
- Reset (rst_i low, asynchronous): count, pointers, starve count and all live bits clear. While reset is asserted: rf_we_o=0, stall_o=0, lu_ready_o=0, busy_o=0, chk_hit_o=0, rf_addr_o=0, rf_data_o=0. Reset mid-operation discards queued results.
- Pipe path: zero latency; port outputs are combinational from pipe inputs.
- Queue path: a result accepted at edge N is visible on the port no earlier than the cycle after N.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- stall_o asserts for exactly one cycle per force event. The next force needs STARVE_MAX further denied cycles.

## Configuration
- WB_ARB_CHK_EN defined: pending-write compare logic is built and chk_hit_o behaves as above.
- WB_ARB_CHK_EN undefined: the compare logic is omitted, chk_hit_o is tied 0, and chk_addr_i is ignored. The decode stage must then stall on busy_o instead.

## Test plan
- Idle pipe: lu writes r3=0x11 at edge 0 → rf_we_o=1, rf_addr_o=3, rf_data_o=0x11 in cycle 1; busy_o=0 after edge 1.
- Fill: 4 lu results, pipe writing every cycle → lu_ready_o=0 after the 4th; a 5th held with lu_valid_i is not accepted; queue contents and order preserved.
- Starvation (STARVE_MAX=8): queue holds r5, pipe writes continuously → stall_o=1 exactly in the 9th cycle, port writes r5, pipe data re-presented and written the following cycle.
- WAW kill: queue holds r7=0xAA, pipe writes r7=0xBB → later drain cycle shows rf_we_o=0; chk_addr_i=7 gives chk_hit_o=0 after the kill, 1 before it.
- r0 and reset: lu write to r0 is accepted, busy_o stays 0. rst_i pulsed low with 3 entries queued → all outputs 0 immediately, count 0 after release.
